de2_115_camera_addr_sequencer: RTL and testbench

- Parametrised Avalon-MM output port that drives an address/index bus to camera-side logic, such as a frame-buffer read address.
- Adds bitwise set/clear writes, hardware auto-increment on an external advance pulse with programmable step and limit, wrap detection, a sticky status flag, a wrap counter, an interrupt and an update strobe.
- Sits between the Nios II data master and the camera read path.

---
 rtl/de2_115_camera_addr_sequencer.sv | 160 ++++++++++++++++
 tb/tb_de2_115_camera_addr_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/de2_115_camera_addr_sequencer.sv
// ---------------------------------------------------------------------------
// de2_115_camera_addr_sequencer
//
// Avalon-MM slave that owns an address/index register (DATA) and drives it to
// the camera read path on out_port. Software can load, bit-set or bit-clear
// DATA. Camera logic can also step DATA by STEP on each advance pulse, with a
// wrap back to 0 when the result would exceed LIMIT. Every wrap sets a sticky
// WRAP flag, bumps a saturating 16-bit wrap counter and can raise an irq.
//
// Ports:
//   clk, reset     - single clock, synchronous active-high reset
//   address        - register select (0 DATA, 1 SET, 2 CLEAR, 3 STEP,
//                    4 LIMIT, 5 CTRL, 6 STATUS, 7 reserved)
//   chipselect     - slave select; a write needs chipselect=1, write_n=0
//   write_n        - active-low write strobe
//   writedata      - 32-bit write data
//   readdata       - combinational zero-extended read data
//   advance        - single-cycle step request from the camera logic
//   out_port       - current DATA value
//   update_strobe  - one-cycle pulse aligned with each new DATA value
//   irq            - registered WRAP & irq_en
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module de2_115_camera_addr_sequencer #(
    parameter int DATA_WIDTH  = 12,
    parameter int RESET_VALUE = 0,
    parameter int STEP_RESET  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  update_strobe,
    output logic                  irq
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_SET    = 3'd1;
    localparam logic [2:0] A_CLEAR  = 3'd2;
    localparam logic [2:0] A_STEP   = 3'd3;
    localparam logic [2:0] A_LIMIT  = 3'd4;
    localparam logic [2:0] A_CTRL   = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;

    localparam logic [DATA_WIDTH-1:0] DATA_RST = DATA_WIDTH'(RESET_VALUE);
    localparam logic [DATA_WIDTH-1:0] STEP_RST = DATA_WIDTH'(STEP_RESET);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] step_q, step_d;
    logic [DATA_WIDTH-1:0] limit_q, limit_d;
    logic [1:0]            ctrl_q, ctrl_d;     // bit0 auto_en, bit1 irq_en
    logic                  wrap_q, wrap_d;
    logic [15:0]           wcnt_q, wcnt_d;
    logic                  strobe_q, strobe_d;
    logic                  irq_q, irq_d;

    logic                  wr_en;
    logic                  data_wr;
    logic                  adv_ok;
    logic                  wrap_evt;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] wd;

    // Only the low DATA_WIDTH bits matter for the data registers; the rest of
    // writedata is consumed by CTRL/STATUS decoding or intentionally dropped.
    logic unused_wd;
    assign unused_wd = ^writedata;

    assign wd = writedata[DATA_WIDTH-1:0];

    always_comb begin
        wr_en    = chipselect & ~write_n;
        // Any software write to DATA/SET/CLEAR takes priority over an advance.
        data_wr  = wr_en & (address <= A_CLEAR);
        adv_ok   = advance & ctrl_q[0] & ~data_wr;
        // One extra bit so the compare against LIMIT sees carry-out.
        sum      = {1'b0, data_q} + {1'b0, step_q};
        wrap_evt = adv_ok & (sum > {1'b0, limit_q});

        data_d   = data_q;
        step_d   = step_q;
        limit_d  = limit_q;
        ctrl_d   = ctrl_q;
        wrap_d   = wrap_q;
        wcnt_d   = wcnt_q;

        if (adv_ok)
            data_d = wrap_evt ? '0 : sum[DATA_WIDTH-1:0];

        if (wr_en) begin
            case (address)
                A_DATA:   data_d  = wd;
                A_SET:    data_d  = data_q | wd;
                A_CLEAR:  data_d  = data_q & ~wd;
                A_STEP:   step_d  = wd;
                A_LIMIT:  limit_d = wd;
                A_CTRL:   ctrl_d  = writedata[1:0];
                A_STATUS: begin
                    if (writedata[0])  wrap_d = 1'b0;
                    if (writedata[31]) wcnt_d = '0;
                end
                default: ;
            endcase
        end

        // Applied after the W1C so a wrap in the same cycle keeps WRAP set.
        if (wrap_evt) begin
            wrap_d = 1'b1;
            if (wcnt_d != 16'hFFFF)
                wcnt_d = wcnt_d + 16'd1;
        end

        strobe_d = data_wr | adv_ok;
        irq_d    = wrap_q & ctrl_q[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= DATA_RST;
            step_q   <= STEP_RST;
            limit_q  <= '1;
            ctrl_q   <= '0;
            wrap_q   <= 1'b0;
            wcnt_q   <= '0;
            strobe_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            data_q   <= data_d;
            step_q   <= step_d;
            limit_q  <= limit_d;
            ctrl_q   <= ctrl_d;
            wrap_q   <= wrap_d;
            wcnt_q   <= wcnt_d;
            strobe_q <= strobe_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            A_DATA, A_SET, A_CLEAR: readdata = 32'(data_q);
            A_STEP:                 readdata = 32'(step_q);
            A_LIMIT:                readdata = 32'(limit_q);
            A_CTRL:                 readdata = {30'd0, ctrl_q};
            A_STATUS:               readdata = {wcnt_q, 15'd0, wrap_q};
            default:                readdata = 32'd0;
        endcase
    end

    assign out_port      = data_q;
    assign update_strobe = strobe_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_de2_115_camera_addr_sequencer.sv
`timescale 1ns/1ps
module tb_de2_115_camera_addr_sequencer;

    localparam int DW   = 12;
    localparam int MASK = (1 << DW) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        advance;
    logic [DW-1:0] out_port;
    logic        update_strobe;
    logic        irq;

    de2_115_camera_addr_sequencer #(.DATA_WIDTH(DW), .RESET_VALUE(0), .STEP_RESET(1)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .advance(advance), .out_port(out_port), .update_strobe(update_strobe),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference state, plain integers
    int m_data, m_step, m_limit, m_ctrl, m_wrap, m_cnt, m_strobe, m_irq;
    logic [31:0] rd_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0, 1, 2: return 32'(m_data);
            3:       return 32'(m_step);
            4:       return 32'(m_limit);
            5:       return 32'(m_ctrl);
            6:       return (32'(m_cnt) << 16) | 32'(m_wrap);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input bit rst, input bit cs, input bit wn, input int a,
                              input logic [31:0] wd, input bit adv);
        int nd, ns, nl, nc, nw, ncnt, sum;
        bit wr, dw, wrap_evt;
        if (rst) begin
            m_data = 0; m_step = 1; m_limit = MASK; m_ctrl = 0;
            m_wrap = 0; m_cnt = 0; m_strobe = 0; m_irq = 0;
            return;
        end
        wr = cs && !wn;
        dw = wr && (a <= 2);
        nd = m_data; ns = m_step; nl = m_limit; nc = m_ctrl; nw = m_wrap; ncnt = m_cnt;
        wrap_evt = 0;
        m_irq = (m_wrap == 1 && (m_ctrl & 2) != 0) ? 1 : 0;
        m_strobe = dw ? 1 : 0;
        if (adv && (m_ctrl & 1) != 0 && !dw) begin
            sum = m_data + m_step;
            m_strobe = 1;
            if (sum > m_limit) begin
                nd = 0;
                wrap_evt = 1;
            end else begin
                nd = sum;
            end
        end
        if (wr) begin
            case (a)
                0: nd = int'(wd) & MASK;
                1: nd = (m_data | int'(wd)) & MASK;
                2: nd = m_data & ~int'(wd) & MASK;
                3: ns = int'(wd) & MASK;
                4: nl = int'(wd) & MASK;
                5: nc = int'(wd) & 3;
                6: begin
                    if (wd[0])  nw = 0;
                    if (wd[31]) ncnt = 0;
                end
                default: ;
            endcase
        end
        if (wrap_evt) begin
            nw = 1;
            ncnt = (ncnt < 65535) ? ncnt + 1 : 65535;
        end
        m_data = nd; m_step = ns; m_limit = nl; m_ctrl = nc; m_wrap = nw; m_cnt = ncnt;
    endtask

    // One bus cycle: drive, check readdata mid-cycle, clock, check outputs.
    task automatic cyc(input bit rst, input bit cs, input bit wn, input int a,
                       input logic [31:0] wd, input bit adv);
        reset = rst; chipselect = cs; write_n = wn; address = 3'(a);
        writedata = wd; advance = adv;
        #2;
        rd_seen = readdata;
        if (!rst) chk("readdata", readdata, m_read(a));
        @(posedge clk);
        model_edge(rst, cs, wn, a, wd, adv);
        #1;
        chk("out_port", 32'(out_port), 32'(m_data));
        chk("strobe", 32'(update_strobe), 32'(m_strobe));
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic wr(input int a, input logic [31:0] wd);
        cyc(0, 1, 0, a, wd, 0);
    endtask

    task automatic idle(input int a);
        cyc(0, 0, 1, a, 32'd0, 0);
    endtask

    task automatic adv_pulse(input int a);
        cyc(0, 0, 1, a, 32'd0, 1);
    endtask

    logic [31:0] exp_rd [8];

    initial begin
        reset = 1; chipselect = 0; write_n = 1; address = 0; writedata = 0; advance = 0;
        @(posedge clk); #1;
        cyc(1, 0, 1, 0, 32'd0, 0);
        chk("rst_out_port", 32'(out_port), 32'd0);
        chk("rst_strobe", 32'(update_strobe), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        exp_rd = '{32'h0, 32'h0, 32'h0, 32'h1, 32'hFFF, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            idle(i);
            chk($sformatf("rst_rd%0d", i), rd_seen, exp_rd[i]);
        end

        // DATA / SET / CLEAR
        wr(0, 32'hABC);       chk("wr_data", 32'(out_port), 32'hABC); chk("wr_strobe", 32'(update_strobe), 1);
        wr(1, 32'h003);       chk("set", 32'(out_port), 32'hABF);     chk("set_strobe", 32'(update_strobe), 1);
        wr(2, 32'h0F0);       chk("clear", 32'(out_port), 32'hA0F);
        idle(0);              chk("strobe_drop", 32'(update_strobe), 0);
        wr(0, 32'hFFFF_F123); chk("wr_trunc", 32'(out_port), 32'h123);

        // auto-increment with wrap
        wr(3, 4); wr(4, 10); wr(5, 1); wr(0, 0);
        adv_pulse(0); chk("adv1", 32'(out_port), 4);
        adv_pulse(0); chk("adv2", 32'(out_port), 8);
        adv_pulse(0); chk("adv3_wrap", 32'(out_port), 0);
        adv_pulse(6); chk("status_wrap", rd_seen, 32'h0001_0001);
        chk("adv4", 32'(out_port), 4);

        // irq path
        wr(6, 1); wr(5, 3);
        adv_pulse(0); adv_pulse(0);          // 8, then wrap to 0
        chk("wrap2", 32'(out_port), 0);
        idle(6); chk("irq_set", 32'(irq), 1);
        wr(6, 1);
        idle(6); chk("irq_clr", 32'(irq), 0); chk("cnt_kept", rd_seen, 32'h0002_0000);
        wr(6, 32'h8000_0000);
        idle(6); chk("cnt_clr", rd_seen, 32'h0);

        // collisions
        wr(0, 8);
        cyc(0, 1, 0, 0, 32'h055, 1); chk("coll_data", 32'(out_port), 32'h055);
        idle(6); chk("coll_nowrap", rd_seen, 32'h0); chk("coll_single_strobe", 32'(update_strobe), 0);
        wr(0, 8);
        cyc(0, 1, 0, 6, 32'h1, 1);   // wrapping step with W1C
        idle(6); chk("w1c_set_wins", rd_seen & 32'h1, 32'h1);

        // reset mid-burst, then disabled advance
        adv_pulse(0); adv_pulse(0);
        cyc(1, 0, 1, 0, 32'd0, 1);
        chk("rst_burst_out", 32'(out_port), 0); chk("rst_burst_strobe", 32'(update_strobe), 0);
        wr(0, 32'h321);
        adv_pulse(0); chk("dis_out", 32'(out_port), 32'h321); chk("dis_strobe", 32'(update_strobe), 0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int a;
            logic [31:0] wd;
            bit w, r, ad;
            a  = $urandom_range(0, 7);
            w  = ($urandom_range(0, 2) == 0);
            ad = ($urandom_range(0, 1) == 1);
            r  = ($urandom_range(0, 199) == 0);
            wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            if (a == 5 && $urandom_range(0, 3) != 0) wd = wd | 32'h1;
            cyc(r, w ? 1'b1 : 1'($urandom_range(0, 1)), !w, a, wd, ad);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
